// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - access size encodings carried on cpu_size
//   - FSM state type
//   - alignment check and store lane mapping helpers
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } store_lanes_t;

    // The reserved size encoding is rejected the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    // Right-justified store data is replicated across every lane it could
    // occupy, so the strobes alone select which bytes the memory updates.
    function automatic store_lanes_t store_lanes(input logic [1:0]  size,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [31:0] data);
        store_lanes_t lanes;
        lanes = '0;
        case (size)
            SIZE_BYTE: begin
                lanes.wstrb = 4'b0001 << addr_lo;
                lanes.wdata = {4{data[7:0]}};
            end
            SIZE_HALF: begin
                lanes.wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                lanes.wdata = {2{data[15:0]}};
            end
            SIZE_WORD: begin
                lanes.wstrb = 4'b1111;
                lanes.wdata = data;
            end
            default: lanes = '0;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it to 32 bits. Words pass through unchanged.
//   rdata     in  32  raw memory word
//   addr_lo   in  2   byte offset of the access
//   size      in  2   access size (lsu_pkg SIZE_*)
//   is_signed in  1   1 = sign-extend, 0 = zero-extend
//   data      out 32  extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            SIZE_BYTE: data = {{24{is_signed & byte_lane[7]}}, byte_lane};
            SIZE_HALF: data = {{16{is_signed & half_lane[15]}}, half_lane};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: CPU-side initiator for the single-port data memory bus.
// Accepts one op at a time, issues a single-cycle request, waits for ack and
// returns extended load data, a store completion, a misalignment reject or a
// bus timeout.
//   clock, resetn                         clock / async active-low reset
//   cpu_valid/ready/write/size/signed     execute-stage handshake and op
//   cpu_addr, cpu_wdata                   byte address, right-justified data
//   resp_valid/data/misaligned/timeout    registered one-cycle responses
//   mem_request/address/write/wstrb/wdata registered bus request
//   mem_rdata, mem_ack                    bus completion
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_misaligned,
    output logic        resp_timeout,
    output logic        mem_request,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

    state_t       state, next_state;
    logic [15:0]  counter;
    logic [1:0]   lat_addr_lo;
    logic [1:0]   lat_size;
    logic         lat_signed;
    logic         lat_write;
    logic         misaligned;
    store_lanes_t lanes;
    logic [31:0]  load_data;

    assign cpu_ready  = (state == IDLE);
    assign misaligned = is_misaligned(cpu_size, cpu_addr[1:0]);
    assign lanes      = store_lanes(cpu_size, cpu_addr[1:0], cpu_wdata);

    lsu_load_align u_load_align (
        .rdata     (mem_rdata),
        .addr_lo   (lat_addr_lo),
        .size      (lat_size),
        .is_signed (lat_signed),
        .data      (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (cpu_valid && !misaligned) next_state = BUSY;
            BUSY: if (mem_ack || counter == LAST_COUNT) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            counter         <= '0;
            lat_addr_lo     <= '0;
            lat_size        <= '0;
            lat_signed      <= 1'b0;
            lat_write       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_misaligned <= 1'b0;
            resp_timeout    <= 1'b0;
            mem_request     <= 1'b0;
            mem_address     <= '0;
            mem_write       <= 1'b0;
            mem_wstrb       <= '0;
            mem_wdata       <= '0;
        end else begin
            // Pulse outputs default low; bus fields hold until the next accept.
            mem_request     <= 1'b0;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_misaligned <= 1'b0;
            resp_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        if (misaligned) begin
                            resp_misaligned <= 1'b1;
                        end else begin
                            mem_request <= 1'b1;
                            mem_address <= {cpu_addr[31:2], 2'b00};
                            mem_write   <= cpu_write;
                            mem_wstrb   <= cpu_write ? lanes.wstrb : 4'b0000;
                            mem_wdata   <= cpu_write ? lanes.wdata : 32'h0;
                            lat_addr_lo <= cpu_addr[1:0];
                            lat_size    <= cpu_size;
                            lat_signed  <= cpu_signed;
                            lat_write   <= cpu_write;
                            counter     <= '0;
                        end
                    end
                end
                BUSY: begin
                    counter <= counter + 16'd1;
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        resp_valid <= 1'b1;
                        resp_data  <= lat_write ? 32'h0 : load_data;
                    end else if (counter == LAST_COUNT) begin
                        resp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
